// File: rtl/ram_access_arbiter.sv
// ----------------------------------------------------------------------------
// ram_access_arbiter
//
// Shares the single-port 16x16 distributed data RAM between two requesters
// (port 0: core load/store unit, port 1: program loader / debug port). One
// RAM access is sequenced at a time over a registered address / write-data /
// write-enable bus. The completion is returned with a one-cycle rvalid pulse
// together with the captured data.
//
// Sequence per access: IDLE/RESP (arbitrate) -> ACCESS (gnt, bus driven)
// -> RESP (rvalid). A request still high in RESP is arbitrated immediately,
// so back-to-back traffic sustains one access every two cycles.
//
// Build option:
//   ARB_RR_EN  defined   : round-robin tie-break (loser of the last grant wins)
//              undefined : fixed priority, port 0 wins every tie
//
// Ports:
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   pN_req/we/addr/wdata requester N access request and its attributes
//   pN_gnt               requester N grant pulse (ACCESS cycle)
//   pN_rvalid/rdata      requester N completion pulse and returned data
//   mem_addr/wdata/we    registered bus to the RAM
//   mem_rdata            combinational read data from the RAM
//   busy                 high while in ACCESS or RESP
// ----------------------------------------------------------------------------
module ram_access_arbiter #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              p0_req,
   input  logic              p0_we,
   input  logic [ADDR_W-1:0] p0_addr,
   input  logic [DATA_W-1:0] p0_wdata,
   output logic              p0_gnt,
   output logic              p0_rvalid,
   output logic [DATA_W-1:0] p0_rdata,
   input  logic              p1_req,
   input  logic              p1_we,
   input  logic [ADDR_W-1:0] p1_addr,
   input  logic [DATA_W-1:0] p1_wdata,
   output logic              p1_gnt,
   output logic              p1_rvalid,
   output logic [DATA_W-1:0] p1_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_RESP   = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic              win_q, win_d;               // 0 = port 0 owns the access
   logic              last_grant_q, last_grant_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic              mem_we_q, mem_we_d;
   logic [1:0]        gnt_q, gnt_d;
   logic [1:0]        rvalid_q, rvalid_d;
   logic [DATA_W-1:0] rdata0_q, rdata0_d;
   logic [DATA_W-1:0] rdata1_q, rdata1_d;
   logic              busy_q, busy_d;

   logic              any_req;
   logic              pick1;
   logic [DATA_W-1:0] cap_data;

   assign any_req = p0_req | p1_req;

   // Winner selection: a lone requester always wins; only ties differ.
`ifdef ARB_RR_EN
   assign pick1 = p1_req & (~p0_req | ~last_grant_q);
`else
   assign pick1 = p1_req & ~p0_req;
`endif

   // A write completes with the value just stored at that address. The RAM
   // commits the write on the same edge that closes ACCESS, so its
   // combinational read port still shows the old word at that instant; the
   // latched write data is the read-back of the written location.
   assign cap_data = mem_we_q ? mem_wdata_q : mem_rdata;

   always_comb begin
      state_d      = state_q;
      win_d        = win_q;
      last_grant_d = last_grant_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      mem_we_d     = 1'b0;
      gnt_d        = 2'b00;
      rvalid_d     = 2'b00;
      rdata0_d     = rdata0_q;
      rdata1_d     = rdata1_q;

      unique case (state_q)
         S_IDLE, S_RESP: begin
            if (any_req) begin
               state_d      = S_ACCESS;
               win_d        = pick1;
               last_grant_d = pick1;
               mem_addr_d   = pick1 ? p1_addr  : p0_addr;
               mem_wdata_d  = pick1 ? p1_wdata : p0_wdata;
               mem_we_d     = pick1 ? p1_we    : p0_we;
               gnt_d        = pick1 ? 2'b10    : 2'b01;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_ACCESS: begin
            state_d  = S_RESP;
            rvalid_d = win_q ? 2'b10 : 2'b01;
            if (win_q) rdata1_d = cap_data;
            else       rdata0_d = cap_data;
         end
         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         win_q        <= 1'b0;
         last_grant_q <= 1'b1;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         mem_we_q     <= 1'b0;
         gnt_q        <= 2'b00;
         rvalid_q     <= 2'b00;
         rdata0_q     <= '0;
         rdata1_q     <= '0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         win_q        <= win_d;
         last_grant_q <= last_grant_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         mem_we_q     <= mem_we_d;
         gnt_q        <= gnt_d;
         rvalid_q     <= rvalid_d;
         rdata0_q     <= rdata0_d;
         rdata1_q     <= rdata1_d;
         busy_q       <= busy_d;
      end
   end

   assign p0_gnt    = gnt_q[0];
   assign p1_gnt    = gnt_q[1];
   assign p0_rvalid = rvalid_q[0];
   assign p1_rvalid = rvalid_q[1];
   assign p0_rdata  = rdata0_q;
   assign p1_rdata  = rdata1_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_we    = mem_we_q;
   assign busy      = busy_q;

endmodule
